accum_requant: RTL and testbench

//  Downstream stage of the systolic MAC array. Takes signed 32-bit accumulator

---
 rtl/accum_requant.sv | 168 ++++++++++++++++
 tb/tb_accum_requant.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_requant.sv
// INT8 requantization stage behind the MAC array.
// Three-stage pipeline: scale, round-shift/ReLU/zero-point, then saturate.
module accum_requant #(
  parameter int ACC_W   = 32,
  parameter int SCALE_W = 16,
  parameter int SHIFT_W = 5,
  parameter int OUT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [SCALE_W-1:0] cfg_scale,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic [OUT_W-1:0]   cfg_zero_point,
  input  logic               cfg_relu,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [ACC_W-1:0]   s_accum,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [OUT_W-1:0]   m_data,
  output logic               m_last,
  output logic [15:0]        sat_count
);

  localparam int PROD_W = ACC_W + SCALE_W + 1;
  localparam logic signed [PROD_W-1:0] V_MAX = PROD_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] V_MIN = PROD_W'(-(2 ** (OUT_W - 1)));

  // Returns {saturated, clamped value}.
  function automatic logic [OUT_W:0] sat_fn(input logic signed [PROD_W-1:0] v);
    logic [OUT_W:0] res;
    if (v > V_MAX) begin
      res = {1'b1, V_MAX[OUT_W-1:0]};
    end else if (v < V_MIN) begin
      res = {1'b1, V_MIN[OUT_W-1:0]};
    end else begin
      res = {1'b0, v[OUT_W-1:0]};
    end
    return res;
  endfunction

  logic                      en;
  logic [SCALE_W-1:0]        scale_q;
  logic [SHIFT_W-1:0]        shift_q;
  logic [OUT_W-1:0]          zp_q;
  logic                      relu_q;

  logic                      v1_q, last1_q, relu1_q;
  logic signed [PROD_W-1:0]  prod1_q;
  logic [SHIFT_W-1:0]        shift1_q;
  logic [OUT_W-1:0]          zp1_q;
  logic                      v2_q, last2_q;
  logic signed [PROD_W-1:0]  val2_q;
  logic                      m_valid_q, m_last_q, sat3_q;
  logic [OUT_W-1:0]          m_data_q;
  logic [15:0]               sat_count_q;

  logic signed [PROD_W-1:0]  prod_d, rnd_d, sum_d, shr_d, val_d;
  logic [OUT_W:0]            satres_d;
  logic [15:0]               sat_count_d;

  assign en      = !m_valid_q || m_ready;
  assign s_ready = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      scale_q <= {{(SCALE_W-1){1'b0}}, 1'b1};
      shift_q <= '0;
      zp_q    <= '0;
      relu_q  <= 1'b0;
    end else if (cfg_we) begin
      scale_q <= cfg_scale;
      shift_q <= cfg_shift;
      zp_q    <= cfg_zero_point;
      relu_q  <= cfg_relu;
    end
  end

  // Operands widened so the full product fits; scale is treated as unsigned.
  always_comb begin
    prod_d = $signed({{(PROD_W-ACC_W){s_accum[ACC_W-1]}}, s_accum}) *
             $signed({{(PROD_W-SCALE_W){1'b0}}, scale_q});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      last1_q  <= 1'b0;
      relu1_q  <= 1'b0;
      prod1_q  <= '0;
      shift1_q <= '0;
      zp1_q    <= '0;
    end else if (en) begin
      v1_q     <= s_valid;
      last1_q  <= s_last;
      relu1_q  <= relu_q;
      prod1_q  <= prod_d;
      shift1_q <= shift_q;
      zp1_q    <= zp_q;
    end
  end

  // Rounding constant is 2^(shift-1), which collapses to zero for shift==0.
  always_comb begin
    rnd_d = ({{(PROD_W-1){1'b0}}, 1'b1} << shift1_q) >> 1;
    sum_d = prod1_q + rnd_d;
    shr_d = sum_d >>> shift1_q;
    if (relu1_q && shr_d[PROD_W-1]) begin
      shr_d = '0;
    end else begin
      shr_d = shr_d;
    end
    val_d = shr_d + $signed({{(PROD_W-OUT_W){zp1_q[OUT_W-1]}}, zp1_q});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      val2_q  <= '0;
    end else if (en) begin
      v2_q    <= v1_q;
      last2_q <= last1_q;
      val2_q  <= val_d;
    end
  end

  assign satres_d = sat_fn(val2_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      sat3_q    <= 1'b0;
    end else if (en) begin
      m_valid_q <= v2_q;
      m_data_q  <= satres_d[OUT_W-1:0];
      m_last_q  <= last2_q;
      sat3_q    <= satres_d[OUT_W];
    end
  end

  // Counted on the transfer edge only, sticking at all-ones.
  always_comb begin
    if (m_valid_q && m_ready && sat3_q && (sat_count_q != 16'hFFFF)) begin
      sat_count_d = sat_count_q + 16'd1;
    end else begin
      sat_count_d = sat_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count_q <= 16'd0;
    end else begin
      sat_count_q <= sat_count_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_accum_requant.sv
// Scoreboard bench for accum_requant: expected beats are queued on accept
// and compared on transfer; inputs change on negedge, sampling just before posedge.
module tb_accum_requant;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [15:0] cfg_scale;
  logic [4:0]  cfg_shift;
  logic [7:0]  cfg_zero_point;
  logic        cfg_relu;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_accum;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic [15:0] sat_count;

  accum_requant dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_scale(cfg_scale),
    .cfg_shift(cfg_shift), .cfg_zero_point(cfg_zero_point), .cfg_relu(cfg_relu),
    .s_valid(s_valid), .s_ready(s_ready), .s_accum(s_accum), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .sat_count(sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       sat;
    int         cyc;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          exp_sat = 0;
  bit          lat_chk = 1'b0;
  int unsigned m_scale = 1;
  int          m_shift = 0;
  int          m_zp = 0;
  bit          m_relu = 1'b0;
  bit          stall_prev = 1'b0;
  logic [7:0]  prev_data;
  logic        prev_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [8:0] model(input int acc, input int unsigned sc, input int sh,
                                       input int zp, input bit relu);
    longint p, r, v;
    p = longint'(acc) * longint'(sc);
    if (sh == 0) r = p;
    else r = (p + (longint'(1) <<< (sh - 1))) >>> sh;
    if (relu && r < 0) r = 0;
    v = r + longint'(zp);
    if (v > 127) return {1'b1, 8'h7F};
    else if (v < -128) return {1'b1, 8'h80};
    else return {1'b0, v[7:0]};
  endfunction

  // Monitor/scoreboard, sampling 1 time unit before each rising edge.
  always begin
    exp_t       e;
    logic [8:0] r;
    @(negedge clk);
    #4;
    cyc++;
    if (rst) begin
      q.delete();
      m_scale = 1; m_shift = 0; m_zp = 0; m_relu = 1'b0;
      exp_sat = 0;
      stall_prev = 1'b0;
    end else begin
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          chk("spurious_beat", {24'd0, m_data}, 32'hDEAD);
        end else begin
          e = q.pop_front();
          chk("m_data", {24'd0, m_data}, {24'd0, e.data});
          chk("m_last", {31'd0, m_last}, {31'd0, e.last});
          if (e.sat && exp_sat < 65535) exp_sat++;
          if (lat_chk) chk("latency", cyc - e.cyc, 32'd3);
        end
      end
      if (m_valid && !m_ready) begin
        chk("s_ready_stall", {31'd0, s_ready}, 32'd0);
        if (stall_prev) begin
          chk("hold_data", {24'd0, m_data}, {24'd0, prev_data});
          chk("hold_last", {31'd0, m_last}, {31'd0, prev_last});
        end
        stall_prev = 1'b1;
        prev_data = m_data;
        prev_last = m_last;
      end else begin
        stall_prev = 1'b0;
      end
      if (s_valid && s_ready) begin
        r = model($signed(s_accum), m_scale, m_shift, $signed(m_zp), m_relu);
        e.data = r[7:0];
        e.sat  = r[8];
        e.last = s_last;
        e.cyc  = cyc;
        q.push_back(e);
      end
      if (cfg_we) begin
        m_scale = cfg_scale;
        m_shift = cfg_shift;
        m_zp    = $signed(cfg_zero_point);
        m_relu  = cfg_relu;
      end
    end
  end

  // Drive one beat starting at a negedge; returns on the negedge after it is accepted.
  task automatic send(input logic [31:0] a, input logic l);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_accum = a;
    s_last  = l;
    #4;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      #4;
      n++;
    end
    if (n >= 100) chk("accept_timeout", n, 32'd0);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic cfg_set(input logic [15:0] sc, input logic [4:0] sh,
                         input logic [7:0] zp, input logic rl);
    cfg_scale = sc; cfg_shift = sh; cfg_zero_point = zp; cfg_relu = rl;
    cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || m_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout", q.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_scale = 16'd1; cfg_shift = 5'd0;
    cfg_zero_point = 8'd0; cfg_relu = 1'b0; s_valid = 1'b0; s_accum = 32'd0;
    s_last = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #4;
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    chk("rst_m_last", {31'd0, m_last}, 32'd0);
    chk("rst_sat_count", {16'd0, sat_count}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    @(negedge clk);

    // 1: defaults, back-to-back, latency checked
    lat_chk = 1'b1;
    send(32'd0, 1'b0);
    send(32'd5, 1'b0);
    send(-32'sd7, 1'b0);
    send(32'd127, 1'b0);
    drain();
    lat_chk = 1'b0;
    chk("t1_sat_count", {16'd0, sat_count}, 32'd0);

    // 2: scale and rounding shift
    cfg_set(16'd3, 5'd2, 8'd0, 1'b0);
    send(32'd100, 1'b0);
    cfg_set(16'd1, 5'd1, 8'd0, 1'b0);
    send(32'd5, 1'b0);
    send(-32'sd5, 1'b0);
    send(-32'sd6, 1'b0);
    drain();

    // 3: saturation
    cfg_set(16'd1, 5'd0, 8'd0, 1'b0);
    send(32'd1000, 1'b0);
    send(-32'sd1000, 1'b0);
    cfg_set(16'hFFFF, 5'd0, 8'd0, 1'b0);
    send(32'h7FFF_FFFF, 1'b0);
    drain();
    chk("t3_sat_count", {16'd0, sat_count}, 32'd3);

    // 4: ReLU and zero point
    cfg_set(16'd1, 5'd0, 8'd10, 1'b1);
    send(-32'sd50, 1'b0);
    send(32'd20, 1'b0);
    cfg_set(16'd1, 5'd0, 8'h80, 1'b0);
    send(-32'sd1, 1'b0);
    drain();
    chk("t4_sat_count", {16'd0, sat_count}, exp_sat);

    // 5: stream with a downstream stall
    cfg_set(16'd1, 5'd0, 8'd0, 1'b0);
    fork
      begin
        for (int i = 1; i <= 10; i++) send(i, (i == 10) ? 1'b1 : 1'b0);
      end
      begin
        repeat (5) @(negedge clk);
        m_ready = 1'b0;
        repeat (5) @(negedge clk);
        m_ready = 1'b1;
      end
    join
    drain();

    // 6: config change on the accept edge, then reset with beats in flight
    cfg_scale = 16'd1; cfg_shift = 5'd1; cfg_zero_point = 8'd0; cfg_relu = 1'b0;
    cfg_we = 1'b1;
    send(32'd8, 1'b0);
    cfg_we = 1'b0;
    send(32'd8, 1'b0);
    drain();
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #4;
    chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("post_rst_m_data", {24'd0, m_data}, 32'd0);
    chk("post_rst_sat", {16'd0, sat_count}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("post_rst_m_valid", {31'd0, m_valid}, 32'd0);
      @(negedge clk);
      #4;
    end
    @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
